// File: rtl/mux_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_serializer_pkg
//  Description : Shared types for the mux_serializer parallel-to-serial stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_serializer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage : mux_serializer_pkg
`default_nettype wire

// File: rtl/mux_n_1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n_1
//  Description : 2**N-to-1 single-bit multiplexer, purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_n_1 #(
    parameter int N = 3
) (
    input  logic [(2**N)-1:0] in_data,
    input  logic [N-1:0]      sel,
    output logic              out_bit
);

    assign out_bit = in_data[sel];

endmodule : mux_n_1
`default_nettype wire

// File: rtl/mux_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : mux_serializer
//  Description : Valid/ready parallel-to-serial converter that sweeps a
//                mux_n_1 select across a held word, with last-bit framing.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_serializer #(
    parameter int N         = 3,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [(2**N)-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic [N-1:0]      sel,
    output logic              busy
);

    import mux_serializer_pkg::*;

    localparam int           W         = 2**N;
    localparam logic [N-1:0] START_IDX = LSB_FIRST ? '0 : '1;
    localparam logic [N-1:0] END_IDX   = LSB_FIRST ? '1 : '0;

    state_e         state_q, state_d;
    logic [W-1:0]   hold_q,  hold_d;
    logic [N-1:0]   sel_q,   sel_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            sel_q   <= START_IDX;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
        end
    end

    assign ser_valid = (state_q == ST_SHIFT);
    assign ser_last  = ser_valid && (sel_q == END_IDX);
    // Accepting on the last transfer lets the next word start with no bubble.
    assign in_ready  = (state_q == ST_IDLE) || (ser_last && ser_ready);
    assign busy      = ser_valid;
    assign sel       = sel_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    hold_d  = in_data;
                    sel_d   = START_IDX;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ser_ready) begin
                    if (ser_last) begin
                        if (in_valid) begin
                            hold_d = in_data;
                            sel_d  = START_IDX;
                        end else begin
                            state_d = ST_IDLE;
                            sel_d   = START_IDX;
                        end
                    end else if (LSB_FIRST) begin
                        sel_d = sel_q + N'(1);
                    end else begin
                        sel_d = sel_q - N'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    mux_n_1 #(
        .N (N)
    ) u_mux (
        .in_data (hold_q),
        .sel     (sel_q),
        .out_bit (ser_out)
    );

endmodule : mux_serializer
`default_nettype wire
